// File: rtl/iob_cache_perf_pkg.sv
// Shared types and constants for the cache performance/control stage.
package iob_cache_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLR       = 2'd1,
        ST_INV_PULSE = 2'd2,
        ST_INV_WAIT  = 2'd3
    } state_t;

    localparam int NCNT = 6;

    localparam int RW_HIT     = 0;
    localparam int RW_MISS    = 1;
    localparam int READ_HIT   = 2;
    localparam int READ_MISS  = 3;
    localparam int WRITE_HIT  = 4;
    localparam int WRITE_MISS = 5;

endpackage

// File: rtl/iob_cache_perf_cnt.sv
// Single performance counter: synchronous clear, increment, saturate or wrap at all-ones.
module iob_cache_perf_cnt #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             arst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] value_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic at_max;
    assign at_max = &value_o;

    // Clear has priority over increment; at all-ones either hold or roll over.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            value_o <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                value_o <= '0;
            end else if (inc_i && !(SATURATE && at_max)) begin
                value_o <= value_o + ONE;
            end
        end
    end

endmodule

// File: rtl/iob_cache_perf_ctrl.sv
// Cache performance counters, CSR read responses and clear/invalidate sequencing.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | accepting reads and write strobes
// ST_CLR       | one cycle: all counters forced to zero, events dropped
// ST_INV_PULSE | invalidate_o high for this cycle
// ST_INV_WAIT  | waiting for invalidate_ack_i from the cache core
module iob_cache_perf_ctrl
    import iob_cache_perf_pkg::*;
#(
    parameter int CNT_W    = 32,   // CSR read width is 32
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             arst_n_i,
    input  logic             evt_valid_i,
    input  logic             evt_write_i,
    input  logic             evt_hit_i,
    input  logic             wtb_empty_i,
    input  logic             wtb_full_i,
    input  logic             WTB_EMPTY_ren_i,
    output logic             WTB_EMPTY_rdata_o,
    output logic             WTB_EMPTY_rvalid_o,
    output logic             WTB_EMPTY_rready_o,
    input  logic             WTB_FULL_ren_i,
    output logic             WTB_FULL_rdata_o,
    output logic             WTB_FULL_rvalid_o,
    output logic             WTB_FULL_rready_o,
    input  logic             RW_HIT_ren_i,
    output logic [CNT_W-1:0] RW_HIT_rdata_o,
    output logic             RW_HIT_rvalid_o,
    output logic             RW_HIT_rready_o,
    input  logic             RW_MISS_ren_i,
    output logic [CNT_W-1:0] RW_MISS_rdata_o,
    output logic             RW_MISS_rvalid_o,
    output logic             RW_MISS_rready_o,
    input  logic             READ_HIT_ren_i,
    output logic [CNT_W-1:0] READ_HIT_rdata_o,
    output logic             READ_HIT_rvalid_o,
    output logic             READ_HIT_rready_o,
    input  logic             READ_MISS_ren_i,
    output logic [CNT_W-1:0] READ_MISS_rdata_o,
    output logic             READ_MISS_rvalid_o,
    output logic             READ_MISS_rready_o,
    input  logic             WRITE_HIT_ren_i,
    output logic [CNT_W-1:0] WRITE_HIT_rdata_o,
    output logic             WRITE_HIT_rvalid_o,
    output logic             WRITE_HIT_rready_o,
    input  logic             WRITE_MISS_ren_i,
    output logic [CNT_W-1:0] WRITE_MISS_rdata_o,
    output logic             WRITE_MISS_rvalid_o,
    output logic             WRITE_MISS_rready_o,
    input  logic             RST_CNTRS_wdata_i,
    input  logic             RST_CNTRS_wen_i,
    output logic             RST_CNTRS_wready_o,
    input  logic             INVALIDATE_wdata_i,
    input  logic             INVALIDATE_wen_i,
    output logic             INVALIDATE_wready_o,
    output logic             invalidate_o,
    input  logic             invalidate_ack_i
);

    state_t state;
    logic   idle, clr_accept, inv_accept, clr;

    assign idle       = (state == ST_IDLE);
    assign clr_accept = idle && RST_CNTRS_wen_i && RST_CNTRS_wdata_i;
    assign inv_accept = idle && INVALIDATE_wen_i && INVALIDATE_wdata_i && !clr_accept;
    // Clearing in the accept cycle as well drops the event seen alongside the strobe.
    assign clr        = clr_accept || (state == ST_CLR);

    assign RST_CNTRS_wready_o  = idle;
    assign INVALIDATE_wready_o = idle && !(RST_CNTRS_wen_i && RST_CNTRS_wdata_i);

    // Counter increment decode: one shared total plus one read/write split counter.
    logic [NCNT-1:0] inc;
    always_comb begin
        inc             = '0;
        inc[RW_HIT]     = evt_valid_i &&  evt_hit_i;
        inc[RW_MISS]    = evt_valid_i && !evt_hit_i;
        inc[READ_HIT]   = evt_valid_i &&  evt_hit_i && !evt_write_i;
        inc[READ_MISS]  = evt_valid_i && !evt_hit_i && !evt_write_i;
        inc[WRITE_HIT]  = evt_valid_i &&  evt_hit_i &&  evt_write_i;
        inc[WRITE_MISS] = evt_valid_i && !evt_hit_i &&  evt_write_i;
    end

    logic [CNT_W-1:0] cnt_q [NCNT];

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        iob_cache_perf_cnt #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk_i    (clk_i),
            .cke_i    (cke_i),
            .arst_n_i (arst_n_i),
            .clr_i    (clr),
            .inc_i    (inc[g]),
            .value_o  (cnt_q[g])
        );
    end

    // Bit 0 = WTB_EMPTY, bit 1 = WTB_FULL, bit 2+k = counter k.
    logic [7:0] ren, ren_acc, rvalid_q;
    assign ren = {WRITE_MISS_ren_i, WRITE_HIT_ren_i, READ_MISS_ren_i, READ_HIT_ren_i,
                  RW_MISS_ren_i, RW_HIT_ren_i, WTB_FULL_ren_i, WTB_EMPTY_ren_i};
    assign ren_acc = ren & {8{idle}};

    logic             wtb_empty_q, wtb_full_q;
    logic [CNT_W-1:0] cnt_rdata_q [NCNT];

    // Response register: capture the selected value, rvalid one cycle after ren.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q    <= '0;
            wtb_empty_q <= 1'b0;
            wtb_full_q  <= 1'b0;
            for (int k = 0; k < NCNT; k++) cnt_rdata_q[k] <= '0;
        end else if (cke_i) begin
            rvalid_q <= ren_acc;
            if (ren_acc[0]) wtb_empty_q <= wtb_empty_i;
            if (ren_acc[1]) wtb_full_q  <= wtb_full_i;
            for (int k = 0; k < NCNT; k++) begin
                if (ren_acc[k+2]) cnt_rdata_q[k] <= cnt_q[k];
            end
        end
    end

    assign WTB_EMPTY_rdata_o   = wtb_empty_q;
    assign WTB_FULL_rdata_o    = wtb_full_q;
    assign RW_HIT_rdata_o      = cnt_rdata_q[RW_HIT];
    assign RW_MISS_rdata_o     = cnt_rdata_q[RW_MISS];
    assign READ_HIT_rdata_o    = cnt_rdata_q[READ_HIT];
    assign READ_MISS_rdata_o   = cnt_rdata_q[READ_MISS];
    assign WRITE_HIT_rdata_o   = cnt_rdata_q[WRITE_HIT];
    assign WRITE_MISS_rdata_o  = cnt_rdata_q[WRITE_MISS];

    assign WTB_EMPTY_rvalid_o  = rvalid_q[0];
    assign WTB_FULL_rvalid_o   = rvalid_q[1];
    assign RW_HIT_rvalid_o     = rvalid_q[2];
    assign RW_MISS_rvalid_o    = rvalid_q[3];
    assign READ_HIT_rvalid_o   = rvalid_q[4];
    assign READ_MISS_rvalid_o  = rvalid_q[5];
    assign WRITE_HIT_rvalid_o  = rvalid_q[6];
    assign WRITE_MISS_rvalid_o = rvalid_q[7];

    assign WTB_EMPTY_rready_o  = idle;
    assign WTB_FULL_rready_o   = idle;
    assign RW_HIT_rready_o     = idle;
    assign RW_MISS_rready_o    = idle;
    assign READ_HIT_rready_o   = idle;
    assign READ_MISS_rready_o  = idle;
    assign WRITE_HIT_rready_o  = idle;
    assign WRITE_MISS_rready_o = idle;

    // Control FSM with registered invalidate pulse; clear wins over invalidate.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state        <= ST_IDLE;
            invalidate_o <= 1'b0;
        end else if (cke_i) begin
            invalidate_o <= inv_accept;
            case (state)
                ST_IDLE: begin
                    if (clr_accept)      state <= ST_CLR;
                    else if (inv_accept) state <= ST_INV_PULSE;
                end
                ST_CLR:       state <= ST_IDLE;
                ST_INV_PULSE: state <= invalidate_ack_i ? ST_IDLE : ST_INV_WAIT;
                ST_INV_WAIT:  if (invalidate_ack_i) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    a_evt_known: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        !$isunknown(evt_valid_i));
    a_ren_onehot: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        $onehot0(ren));

endmodule

// File: doc/iob_cache_perf_ctrl.md
Name: iob_cache_perf_ctrl

Overview:
- Control and performance-monitor stage sitting between the cache core and the cache CSR bank.
- Counts read/write hits and misses from per-access events in the cache core.
- Serves counter and write-through-buffer status reads over the CSR bank's per-register ren/rdata/rvalid/rready handshake.
- Executes the CSR bank's RST_CNTRS and INVALIDATE write strobes over the wen/wdata/wready handshake, forwarding invalidate to the cache core with an acknowledge.

Parameters:
- CNT_W, 32, width of each performance counter; must equal the CSR read width of 32.
- SATURATE, 1, 1 = counters hold at all-ones; 0 = counters wrap to 0.

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; when low, all registers hold
- arst_n_i  in  1  asynchronous active-low reset
- evt_valid_i  in  1  one cache access resolved this cycle
- evt_write_i  in  1  access is a write (0 = read)
- evt_hit_i  in  1  access hit (0 = miss)
- wtb_empty_i, wtb_full_i  in  1 each  write-through buffer status from cache core
- X_ren_i  in  1  read strobe, X in {WTB_EMPTY, WTB_FULL, RW_HIT, RW_MISS, READ_HIT, READ_MISS, WRITE_HIT, WRITE_MISS}
- X_rdata_o  out  1 (WTB_*) / CNT_W (counters)  read data
- X_rvalid_o  out  1  read data valid
- X_rready_o  out  1  ready to accept a read
- RST_CNTRS_wdata_i, RST_CNTRS_wen_i  in  1 each  counter-clear request
- RST_CNTRS_wready_o  out  1
- INVALIDATE_wdata_i, INVALIDATE_wen_i  in  1 each  invalidate request
- INVALIDATE_wready_o  out  1
- invalidate_o  out  1  one-cycle invalidate pulse to cache core
- invalidate_ack_i  in  1  cache core finished invalidating

Behaviour:
- Reset (interface fact): one clock; reset is asynchronous and active-low. With arst_n_i = 0:
  - all counters = 0, FSM = IDLE, every rvalid_o = 0, every rdata_o = 0, invalidate_o = 0;
  - every rready_o = 1 and every wready_o = 1.
- Counters:
  - evt_valid_i & evt_hit_i increments RW_HIT and, by evt_write_i, READ_HIT or WRITE_HIT.
  - Miss events increment RW_MISS and READ_MISS or WRITE_MISS in the same way.
  - At most one event per cycle, so at most 2 counters change per cycle.
  - At all-ones: hold if SATURATE = 1, else wrap to 0.
- Reads:
  - A ren in cycle N registers rdata for cycle N+1, with rvalid high for exactly one cycle in N+1.
  - Counter rdata = value before any increment occurring in cycle N.
  - WTB_* rdata = wtb_*_i sampled in cycle N.
  - rready_o is 1 in IDLE and 0 in CLR and INV_WAIT. A ren arriving while rready = 0 is ignored.
- FSM states: IDLE, CLR, INV_PULSE, INV_WAIT.
  - IDLE -> CLR on RST_CNTRS_wen_i & RST_CNTRS_wdata_i.
  - IDLE -> INV_PULSE on INVALIDATE_wen_i & INVALIDATE_wdata_i.
  - Both in the same cycle: CLR is taken first; INVALIDATE_wready_o stays 0 until the request is re-presented from IDLE.
  - A wen with wdata = 0 is accepted with no action.
  - CLR (one cycle): all counters <= 0; any event this cycle is dropped (clear wins); -> IDLE.
  - INV_PULSE: invalidate_o = 1 for one cycle; -> INV_WAIT.
  - INV_WAIT: stays until invalidate_ack_i = 1; -> IDLE. An ack arriving in INV_PULSE is honoured, going directly to IDLE.
  - Counting continues in INV_PULSE and INV_WAIT.
- Write ready:
  - RST_CNTRS_wready_o = 1 only in IDLE.
  - INVALIDATE_wready_o = 1 only in IDLE and not while a clear is being accepted that cycle.
- Reset mid-operation returns to IDLE, drops any pending invalidate and clears counters; invalidate_o drops to 0 immediately (asynchronously).
- cke_i = 0 freezes all state and outputs; events and strobes in those cycles are lost.
- Simulation-only assertion: evt_valid_i must not be X; at most one ren_i high per cycle.

Decomposition:
- Package iob_cache_perf_pkg:
  - FSM state encoding (2-bit);
  - counter index constants RW_HIT = 0 … WRITE_MISS = 5;
  - NCNT = 6.
- Sub-module iob_cache_perf_cnt: one counter with saturate/wrap, clear and increment inputs. Instantiated six times.
- The read-mux/response register and the FSM stay in the top module.

Test Plan:
- Reset, then read all 8 registers -> all rdata = 0, each rvalid exactly one cycle after its ren, rready = 1 throughout.
- 3 read hits, 2 write misses, 1 write hit -> READ_HIT = 3, WRITE_HIT = 1, WRITE_MISS = 2, RW_HIT = 4, RW_MISS = 2, READ_MISS = 0.
- Preload via 2^32-1 events (or force) RW_HIT = 0xFFFFFFFF, then one hit -> reads 0xFFFFFFFF with SATURATE = 1, and 0x0 with SATURATE = 0.
- RST_CNTRS wen with wdata = 1 in the same cycle as a read-hit event -> all counters 0 next cycle (event dropped); rready = 0 during CLR; a read issued after IDLE returns 0.
- INVALIDATE wen with wdata = 1, ack after 5 cycles -> invalidate_o high for exactly 1 cycle, INVALIDATE_wready_o = 0 for 6 cycles, back to IDLE; a second wen during the wait is not accepted.
- Assert arst_n_i during INV_WAIT with RW_MISS = 7 -> invalidate_o = 0, counters 0, wready = 1 after release; a later ack is ignored.
